// File: rtl/spi_pkg.sv
// Shared SPI master definitions: datapath widths and the bit-order helper
// used by both the transmit and receive paths.
package spi_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  // Maps a transfer position to a register bit; MSB-first walks down from bit 7.
  function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] cnt,
                                               input logic             lsbfe);
    return lsbfe ? cnt : (CNT_W'(DATA_W - 1) - cnt);
  endfunction

endpackage

// File: rtl/spi_shift_register.sv
// SPI master serialiser/deserialiser: drives mosi and assembles miso bytes
// at the instants marked by the baud generator's flag pulses.
module spi_shift_register
  import spi_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic              lsbfe,
  input  logic              cpha,
  input  logic              cpol,
  input  logic              flag_low,
  input  logic              flag_high,
  input  logic              flags_low,
  input  logic              flags_high,
  input  logic              miso,
  input  logic              receive_data,
  input  logic [DATA_W-1:0] data_mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              mosi
);

  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic              same;
  logic              drive;
  logic              sample;

  // Modes 0 and 3 drive ahead of the falling edge and sample on the rising edge.
  always_comb begin
    same   = (cpha == cpol);
    drive  = same ? flags_low : flags_high;
    sample = same ? flag_high : flag_low;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_reg    <= '0;
      rx_reg    <= '0;
      data_miso <= '0;
      mosi      <= 1'b0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
    end else begin
      if (send_data) begin
        tx_reg <= data_mosi;
      end

      // While idle, pre-present the first bit so cpha=0 has data before the first edge.
      if (ss) begin
        tx_cnt <= '0;
        rx_cnt <= '0;
        mosi   <= lsbfe ? tx_reg[0] : tx_reg[DATA_W-1];
      end else begin
        if (drive) begin
          mosi   <= tx_reg[bit_idx(tx_cnt, lsbfe)];
          tx_cnt <= tx_cnt + CNT_W'(1);
        end
        if (sample) begin
          rx_reg[bit_idx(rx_cnt, lsbfe)] <= miso;
          rx_cnt                         <= rx_cnt + CNT_W'(1);
        end
      end

      if (receive_data) begin
        data_miso <= rx_reg;
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// Self-checking bench for spi_shift_register: directed scenarios followed by
// randomized transfers compared against a bit-queue reference model.
module tb_spi_shift_register;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       ss;
  logic       send_data;
  logic       lsbfe;
  logic       cpha;
  logic       cpol;
  logic       flag_low;
  logic       flag_high;
  logic       flags_low;
  logic       flags_high;
  logic       miso;
  logic       receive_data;
  logic [7:0] data_mosi;
  logic [7:0] data_miso;
  logic       mosi;

  int checks   = 0;
  int failures = 0;

  bit txExp[$];
  bit rxSeen[$];

  spi_shift_register dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .ss          (ss),
    .send_data   (send_data),
    .lsbfe       (lsbfe),
    .cpha        (cpha),
    .cpol        (cpol),
    .flag_low    (flag_low),
    .flag_high   (flag_high),
    .flags_low   (flags_low),
    .flags_high  (flags_high),
    .miso        (miso),
    .receive_data(receive_data),
    .data_mosi   (data_mosi),
    .data_miso   (data_miso),
    .mosi        (mosi)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One clock with the given flag pattern and miso value, then flags return low.
  task automatic applyStimulus(input logic fl, input logic fh, input logic fsl,
                               input logic fsh, input logic m);
    flag_low   = fl;
    flag_high  = fh;
    flags_low  = fsl;
    flags_high = fsh;
    miso       = m;
    tick();
    flag_low   = 1'b0;
    flag_high  = 1'b0;
    flags_low  = 1'b0;
    flags_high = 1'b0;
  endtask

  function automatic bit sameMode();
    return cpha == cpol;
  endfunction

  task automatic pulseDrive();
    if (sameMode()) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    else            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pulseSample(input logic m);
    if (sameMode()) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, m);
    else            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, m);
  endtask

  task automatic setMode(input int mode, input logic lsb);
    cpol  = mode[1];
    cpha  = mode[0];
    lsbfe = lsb;
  endtask

  // Two cycles: one to capture the byte, one for idle mosi to reflect it.
  task automatic loadByte(input logic [7:0] b);
    data_mosi = b;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    tick();
  endtask

  task automatic buildTx(input logic [7:0] b, input logic lsb);
    int v;
    v = b;
    txExp = {};
    for (int k = 0; k < 8; k++) begin
      if (lsb) txExp.push_back(bit'(v % 2));
      else     txExp.push_front(bit'(v % 2));
      v = v / 2;
    end
  endtask

  function automatic logic [7:0] foldRx(input logic lsb);
    int v;
    v = 0;
    if (lsb) for (int i = rxSeen.size() - 1; i >= 0; i--) v = v * 2 + int'(rxSeen[i]);
    else     for (int i = 0; i < rxSeen.size(); i++)       v = v * 2 + int'(rxSeen[i]);
    return 8'(v);
  endfunction

  initial begin
    logic [7:0] pat;
    logic [7:0] rxPat;
    logic [7:0] rb;
    int         mode;
    logic       lsb;
    logic       mb;

    PRESETn = 1'b0; ss = 1'b1; send_data = 1'b0; lsbfe = 1'b0; cpha = 1'b0; cpol = 1'b0;
    flag_low = 1'b0; flag_high = 1'b0; flags_low = 1'b0; flags_high = 1'b0;
    miso = 1'b0; receive_data = 1'b0; data_mosi = 8'h00;

    // Reset state and quiet release
    #12;
    checkOutput("reset_mosi", {7'b0, mosi}, 8'h00);
    checkOutput("reset_data_miso", data_miso, 8'h00);
    PRESETn = 1'b1;
    tick();
    tick();
    checkOutput("release_mosi", {7'b0, mosi}, 8'h00);
    checkOutput("release_data_miso", data_miso, 8'h00);

    // Mode 0, MSB first, 0xAA, wrong-mode pulses ignored
    setMode(0, 1'b0);
    loadByte(8'hAA);
    buildTx(8'hAA, 1'b0);
    checkOutput("m0_idle_mosi", {7'b0, mosi}, {7'b0, txExp[0]});
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulseDrive();
      checkOutput($sformatf("m0_bit%0d", i), {7'b0, mosi}, {7'b0, txExp.pop_front()});
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("m0_ignore%0d", i), {7'b0, mosi}, {7'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
    end

    // Mode 1, LSB first, 0x35
    ss = 1'b1;
    setMode(1, 1'b1);
    loadByte(8'h35);
    pat = 8'b0011_0101;
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulseDrive();
      checkOutput($sformatf("m1_bit%0d", i), {7'b0, mosi}, {7'b0, pat[i]});
    end

    // Receive mode 0, MSB first, expect 0xCB
    ss = 1'b1;
    setMode(0, 1'b0);
    tick();
    ss = 1'b0;
    rxPat = 8'hCB;
    for (int i = 7; i >= 0; i--) pulseSample(rxPat[i]);
    checkOutput("rx_before_copy", data_miso, 8'h00);
    receive_data = 1'b1;
    tick();
    receive_data = 1'b0;
    checkOutput("rx_cb", data_miso, 8'hCB);

    // Wrap: ninth drive restarts at the MSB
    ss = 1'b1;
    loadByte(8'h96);
    checkOutput("idle_tx7", {7'b0, mosi}, 8'h01);
    ss = 1'b0;
    for (int i = 0; i < 8; i++) pulseDrive();
    checkOutput("wrap_last", {7'b0, mosi}, 8'h00);
    pulseDrive();
    checkOutput("wrap_first", {7'b0, mosi}, 8'h01);
    pulseDrive();
    checkOutput("wrap_second", {7'b0, mosi}, 8'h00);

    // Idle mid-byte restarts both counters
    ss = 1'b1;
    tick();
    ss = 1'b0;
    pulseDrive();
    pulseDrive();
    pulseDrive();
    for (int i = 0; i < 3; i++) pulseSample(1'b1);
    ss = 1'b1;
    tick();
    checkOutput("midbyte_idle_mosi", {7'b0, mosi}, 8'h01);
    ss = 1'b0;
    pulseDrive();
    checkOutput("restart_tx_msb", {7'b0, mosi}, 8'h01);
    pulseDrive();
    checkOutput("restart_tx_next", {7'b0, mosi}, 8'h00);
    rxPat = 8'h5A;
    for (int i = 7; i >= 0; i--) pulseSample(rxPat[i]);
    receive_data = 1'b1;
    tick();
    receive_data = 1'b0;
    checkOutput("restart_rx", data_miso, 8'h5A);

    // Asynchronous reset mid-transfer
    ss = 1'b1;
    loadByte(8'hC3);
    ss = 1'b0;
    pulseDrive();
    pulseDrive();
    pulseDrive();
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("async_mosi", {7'b0, mosi}, 8'h00);
    checkOutput("async_data_miso", data_miso, 8'h00);
    tick();
    #2;
    PRESETn = 1'b1;
    ss = 1'b1;
    loadByte(8'h81);
    ss = 1'b0;
    pulseDrive();
    checkOutput("post_reset_bit0", {7'b0, mosi}, 8'h01);
    pulseDrive();
    checkOutput("post_reset_bit1", {7'b0, mosi}, 8'h00);

    // Randomized full-duplex transfers with stray wrong-mode flags
    for (int t = 0; t < 12; t++) begin
      mode = int'($urandom_range(0, 3));
      lsb  = 1'($urandom_range(0, 1));
      rb   = 8'($urandom);
      ss = 1'b1;
      setMode(mode, lsb);
      loadByte(rb);
      buildTx(rb, lsb);
      checkOutput($sformatf("rnd%0d_idle", t), {7'b0, mosi}, {7'b0, txExp[0]});
      ss = 1'b0;
      rxSeen = {};
      for (int i = 0; i < 8; i++) begin
        mb = 1'($urandom);
        if (sameMode())
          applyStimulus(1'($urandom), 1'b1, 1'b1, 1'($urandom), mb);
        else
          applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'b1, mb);
        rxSeen.push_back(mb);
        checkOutput($sformatf("rnd%0d_tx%0d", t, i), {7'b0, mosi}, {7'b0, txExp.pop_front()});
      end
      ss = 1'b1;
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      checkOutput($sformatf("rnd%0d_rx", t), data_miso, foldRx(lsb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
